// File: rtl/decode_stage.sv
// Decode stage and ID/EX pipeline register for the 5-stage MIPS-subset core.
// Decodes control fields from the fetched instruction and selects operands
// from the register file or the write-back bypass. It registers the result
// for execute and inserts a one-cycle bubble when a load feeds the next instruction.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  input  logic        ex_ready,
  output logic [4:0]  src1_address,
  output logic [4:0]  src2_address,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic        wb_enable,
  input  logic [4:0]  wb_address,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_rs_val,
  output logic [31:0] id_rt_val,
  output logic [31:0] id_imm,
  output logic [31:0] id_branch_target,
  output logic [4:0]  id_dest,
  output logic [2:0]  id_alu_op,
  output logic        id_alu_src_imm,
  output logic        id_mem_read,
  output logic        id_mem_write,
  output logic        id_reg_write,
  output logic        id_branch,
  output logic        id_illegal
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [31:0] branch_target;
    logic [4:0]  dest;
    alu_op_e     alu_op;
    logic        alu_src_imm;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        branch;
    logic        illegal;
  } idex_t;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  idex_t dec;
  idex_t id_d;
  idex_t id_q;
  logic  reads_rs;
  logic  reads_rt;
  logic  stall;
  logic  advance;

  assign opcode       = if_instr[31:26];
  assign rs           = if_instr[25:21];
  assign rt           = if_instr[20:16];
  assign rd           = if_instr[15:11];
  assign funct        = if_instr[5:0];
  assign src1_address = rs;
  assign src2_address = rt;

  // Register r0 reads as zero; a same-edge write-back wins over the stale file value.
  function automatic logic [31:0] pick_operand(input logic [4:0] addr, input logic [31:0] rf_data,
                                               input logic en, input logic [4:0] wa,
                                               input logic [31:0] wd);
    if (addr == 5'd0) return 32'd0;
    else if (en && (wa == addr)) return wd;
    else return rf_data;
  endfunction

  // Combinational decode of the instruction presented by fetch.
  always_comb begin
    dec               = '0;
    dec.alu_op        = ALU_ADD;
    reads_rs          = 1'b0;
    reads_rt          = 1'b0;
    dec.pc            = if_pc;
    dec.imm           = {{16{if_instr[15]}}, if_instr[15:0]};
    dec.branch_target = if_pc + 32'd4 + {dec.imm[29:0], 2'b00};
    dec.rs_val        = pick_operand(rs, reg1, wb_enable, wb_address, wb_data);
    dec.rt_val        = pick_operand(rt, reg2, wb_enable, wb_address, wb_data);
    case (opcode)
      6'h00: begin
        dec.dest      = rd;
        dec.reg_write = 1'b1;
        reads_rs      = 1'b1;
        reads_rt      = 1'b1;
        case (funct)
          6'h20: dec.alu_op = ALU_ADD;
          6'h22: dec.alu_op = ALU_SUB;
          6'h24: dec.alu_op = ALU_AND;
          6'h25: dec.alu_op = ALU_OR;
          6'h2A: dec.alu_op = ALU_SLT;
          default: begin
            dec.illegal   = 1'b1;
            dec.dest      = 5'd0;
            dec.reg_write = 1'b0;
            reads_rs      = 1'b0;
            reads_rt      = 1'b0;
          end
        endcase
      end
      6'h08: begin
        dec.alu_src_imm = 1'b1;
        dec.dest        = rt;
        dec.reg_write   = 1'b1;
        reads_rs        = 1'b1;
      end
      6'h23: begin
        dec.alu_src_imm = 1'b1;
        dec.mem_read    = 1'b1;
        dec.dest        = rt;
        dec.reg_write   = 1'b1;
        reads_rs        = 1'b1;
      end
      6'h2B: begin
        dec.alu_src_imm = 1'b1;
        dec.mem_write   = 1'b1;
        reads_rs        = 1'b1;
        reads_rt        = 1'b1;
      end
      6'h04: begin
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
        reads_rs   = 1'b1;
        reads_rt   = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.dest == 5'd0) dec.reg_write = 1'b0;
  end

  // Hazard detection and handshake: a load in ID/EX blocks a consumer of its result.
  always_comb begin
    advance  = ex_ready | ~id_q.valid;
    stall    = id_q.valid & id_q.mem_read & (id_q.dest != 5'd0) & if_valid &
               ((reads_rs & (rs == id_q.dest)) | (reads_rt & (rt == id_q.dest)));
    if_ready = ~rst & (flush | (advance & ~stall));
  end

  // Next ID/EX contents: flush squashes, a stall injects a bubble, otherwise load or hold.
  always_comb begin
    id_d = id_q;
    if (flush) begin
      id_d.valid = 1'b0;
    end else if (advance) begin
      if (stall) begin
        id_d.valid = 1'b0;
      end else begin
        id_d       = dec;
        id_d.valid = if_valid;
      end
    end
  end

  // ID/EX register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) id_q <= '0;
    else     id_q <= id_d;
  end

  assign id_valid         = id_q.valid;
  assign id_pc            = id_q.pc;
  assign id_rs_val        = id_q.rs_val;
  assign id_rt_val        = id_q.rt_val;
  assign id_imm           = id_q.imm;
  assign id_branch_target = id_q.branch_target;
  assign id_dest          = id_q.dest;
  assign id_alu_op        = id_q.alu_op;
  assign id_alu_src_imm   = id_q.alu_src_imm;
  assign id_mem_read      = id_q.mem_read;
  assign id_mem_write     = id_q.mem_write;
  assign id_reg_write     = id_q.reg_write;
  assign id_branch        = id_q.branch;
  assign id_illegal       = id_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expected values.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_ready;
  logic [4:0]  src1_address;
  logic [4:0]  src2_address;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic        wb_enable;
  logic [4:0]  wb_address;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic [31:0] id_imm;
  logic [31:0] id_branch_target;
  logic [4:0]  id_dest;
  logic [2:0]  id_alu_op;
  logic        id_alu_src_imm;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_reg_write;
  logic        id_branch;
  logic        id_illegal;

  logic [31:0] rf [32];
  int errorCount = 0;
  int checkCount = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  // Register-file model feeding the combinational read ports.
  assign reg1 = rf[src1_address];
  assign reg2 = rf[src2_address];

  decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready),
    .src1_address(src1_address), .src2_address(src2_address),
    .reg1(reg1), .reg2(reg2), .wb_enable(wb_enable), .wb_address(wb_address),
    .wb_data(wb_data), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_branch_target(id_branch_target), .id_dest(id_dest), .id_alu_op(id_alu_op),
    .id_alu_src_imm(id_alu_src_imm), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .id_branch(id_branch), .id_illegal(id_illegal)
  );

  function automatic logic [31:0] encR(input logic [5:0] fn, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [31:0] pc);
    if_valid = valid;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hDEAD0000;
    rf[1] = 32'd100;
    rf[2] = 32'd5;
    rf[5] = 32'd50;
    rf[7] = 32'd7;
    rf[8] = 32'd8;
    rst = 1'b1;
    flush = 1'b0;
    ex_ready = 1'b1;
    wb_enable = 1'b0;
    wb_address = 5'd0;
    wb_data = 32'd0;
    applyStimulus(1'b1, encI(6'h08, 5'd1, 5'd2, 16'h1234), 32'h40);

    // Reset held for two cycles with a valid instruction offered.
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput("rst_if_ready", {31'd0, if_ready}, 32'd0);
      checkOutput("rst_id_valid", {31'd0, id_valid}, 32'd0);
      checkOutput("rst_id_pc", id_pc, 32'd0);
      checkOutput("rst_id_imm", id_imm, 32'd0);
      checkOutput("rst_id_dest", {27'd0, id_dest}, 32'd0);
      checkOutput("rst_id_reg_write", {31'd0, id_reg_write}, 32'd0);
    end
    rst = 1'b0;
    #1;
    checkOutput("post_rst_if_ready", {31'd0, if_ready}, 32'd1);

    // Streaming: ADDI r1, r0, -4 then ADD r3, r1, r2.
    applyStimulus(1'b1, encI(6'h08, 5'd0, 5'd1, 16'hFFFC), 32'h100);
    #1;
    checkOutput("src1_address", {27'd0, src1_address}, 32'd0);
    checkOutput("src2_address", {27'd0, src2_address}, 32'd1);
    tick();
    checkOutput("addi_valid", {31'd0, id_valid}, 32'd1);
    checkOutput("addi_imm", id_imm, 32'hFFFFFFFC);
    checkOutput("addi_dest", {27'd0, id_dest}, 32'd1);
    checkOutput("addi_alu_op", {29'd0, id_alu_op}, 32'd0);
    checkOutput("addi_src_imm", {31'd0, id_alu_src_imm}, 32'd1);
    checkOutput("addi_rs_val_r0", id_rs_val, 32'd0);
    checkOutput("addi_pc", id_pc, 32'h100);
    checkOutput("addi_btarget", id_branch_target, 32'h000000F4);
    applyStimulus(1'b1, encR(6'h20, 5'd1, 5'd2, 5'd3), 32'h104);
    tick();
    checkOutput("add_dest", {27'd0, id_dest}, 32'd3);
    checkOutput("add_reg_write", {31'd0, id_reg_write}, 32'd1);
    checkOutput("add_src_imm", {31'd0, id_alu_src_imm}, 32'd0);
    checkOutput("add_rs_val", id_rs_val, 32'd100);
    checkOutput("add_rt_val", id_rt_val, 32'd5);

    // Write-back bypass on r2, then r0 and a mismatched address.
    wb_enable = 1'b1;
    wb_address = 5'd2;
    wb_data = 32'd9;
    applyStimulus(1'b1, encR(6'h25, 5'd2, 5'd2, 5'd4), 32'h108);
    tick();
    checkOutput("byp_rs_val", id_rs_val, 32'd9);
    checkOutput("byp_rt_val", id_rt_val, 32'd9);
    checkOutput("or_alu_op", {29'd0, id_alu_op}, 32'd3);
    wb_address = 5'd0;
    applyStimulus(1'b1, encR(6'h25, 5'd0, 5'd2, 5'd4), 32'h10C);
    tick();
    checkOutput("byp_r0_rs_val", id_rs_val, 32'd0);
    checkOutput("byp_nomatch_rt_val", id_rt_val, 32'd5);
    wb_enable = 1'b0;

    // Load-use stall: LW r5, 0(r1) then SUB r6, r5, r7.
    applyStimulus(1'b1, encI(6'h23, 5'd1, 5'd5, 16'h0000), 32'h110);
    tick();
    checkOutput("lw_mem_read", {31'd0, id_mem_read}, 32'd1);
    checkOutput("lw_dest", {27'd0, id_dest}, 32'd5);
    applyStimulus(1'b1, encR(6'h22, 5'd5, 5'd7, 5'd6), 32'h114);
    #1;
    checkOutput("stall_if_ready", {31'd0, if_ready}, 32'd0);
    tick();
    checkOutput("bubble_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("after_bubble_if_ready", {31'd0, if_ready}, 32'd1);
    tick();
    checkOutput("sub_valid", {31'd0, id_valid}, 32'd1);
    checkOutput("sub_dest", {27'd0, id_dest}, 32'd6);
    checkOutput("sub_alu_op", {29'd0, id_alu_op}, 32'd1);
    checkOutput("sub_rs_val", id_rs_val, 32'd50);

    // Independent SUB after a load does not stall.
    applyStimulus(1'b1, encI(6'h23, 5'd1, 5'd5, 16'h0000), 32'h118);
    tick();
    applyStimulus(1'b1, encR(6'h22, 5'd8, 5'd7, 5'd6), 32'h11C);
    #1;
    checkOutput("nostall_if_ready", {31'd0, if_ready}, 32'd1);
    tick();
    checkOutput("nostall_valid", {31'd0, id_valid}, 32'd1);
    checkOutput("nostall_rs_val", id_rs_val, 32'd8);

    // SW: memory write, no register destination.
    applyStimulus(1'b1, encI(6'h2B, 5'd1, 5'd7, 16'h0008), 32'h120);
    tick();
    checkOutput("sw_mem_write", {31'd0, id_mem_write}, 32'd1);
    checkOutput("sw_dest", {27'd0, id_dest}, 32'd0);
    checkOutput("sw_reg_write", {31'd0, id_reg_write}, 32'd0);

    // BEQ at 0x200 held downstream for three cycles, then flushed.
    applyStimulus(1'b1, encI(6'h04, 5'd1, 5'd2, 16'h0003), 32'h200);
    tick();
    checkOutput("beq_branch", {31'd0, id_branch}, 32'd1);
    checkOutput("beq_btarget", id_branch_target, 32'h210);
    checkOutput("beq_reg_write", {31'd0, id_reg_write}, 32'd0);
    ex_ready = 1'b0;
    applyStimulus(1'b1, encI(6'h08, 5'd1, 5'd9, 16'h0001), 32'h204);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("hold_if_ready", {31'd0, if_ready}, 32'd0);
      tick();
      checkOutput("hold_pc", id_pc, 32'h200);
      checkOutput("hold_btarget", id_branch_target, 32'h210);
      checkOutput("hold_valid", {31'd0, id_valid}, 32'd1);
    end
    flush = 1'b1;
    #1;
    checkOutput("flush_if_ready", {31'd0, if_ready}, 32'd1);
    tick();
    checkOutput("flush_valid", {31'd0, id_valid}, 32'd0);
    flush = 1'b0;
    ex_ready = 1'b1;

    // Flush wins over a pending load-use stall.
    applyStimulus(1'b1, encI(6'h23, 5'd1, 5'd5, 16'h0000), 32'h300);
    tick();
    applyStimulus(1'b1, encR(6'h22, 5'd5, 5'd7, 5'd6), 32'h304);
    flush = 1'b1;
    #1;
    checkOutput("flush_stall_if_ready", {31'd0, if_ready}, 32'd1);
    tick();
    checkOutput("flush_stall_valid", {31'd0, id_valid}, 32'd0);
    flush = 1'b0;

    // Illegal opcode and unknown R-type funct.
    applyStimulus(1'b1, encI(6'h3F, 5'd1, 5'd3, 16'h0000), 32'h400);
    tick();
    checkOutput("ill_valid", {31'd0, id_valid}, 32'd1);
    checkOutput("ill_flag", {31'd0, id_illegal}, 32'd1);
    checkOutput("ill_ctrl", {28'd0, id_reg_write, id_mem_read, id_mem_write, id_branch}, 32'd0);
    checkOutput("ill_dest", {27'd0, id_dest}, 32'd0);
    applyStimulus(1'b1, encR(6'h21, 5'd1, 5'd2, 5'd3), 32'h404);
    tick();
    checkOutput("ill_funct_flag", {31'd0, id_illegal}, 32'd1);
    checkOutput("ill_funct_reg_write", {31'd0, id_reg_write}, 32'd0);

    // Reset mid-operation.
    rst = 1'b1;
    tick();
    checkOutput("midrst_valid", {31'd0, id_valid}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_if_ready", {31'd0, if_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
